// File: rtl/tx_scheduler_if.sv
// Handshake bundle between two word requesters, the scheduler and a UART transmitter.
interface tx_scheduler_if #(
  parameter int N_DATA = 8,
  parameter int N_WORD = 32
);
  logic              req_a_valid;
  logic [N_WORD-1:0] req_a_data;
  logic [1:0]        req_a_nbytes_m1;
  logic              req_a_ready;
  logic              req_b_valid;
  logic [N_WORD-1:0] req_b_data;
  logic [1:0]        req_b_nbytes_m1;
  logic              req_b_ready;
  logic              tx_start;
  logic [N_DATA-1:0] tx_din;
  logic              tx_idle;
  logic [1:0]        grant;
  logic              busy;
  logic              word_done;

  modport master (
    output req_a_valid, req_a_data, req_a_nbytes_m1,
    output req_b_valid, req_b_data, req_b_nbytes_m1,
    output tx_idle,
    input  req_a_ready, req_b_ready, tx_start, tx_din, grant, busy, word_done
  );

  modport slave (
    input  req_a_valid, req_a_data, req_a_nbytes_m1,
    input  req_b_valid, req_b_data, req_b_nbytes_m1,
    input  tx_idle,
    output req_a_ready, req_b_ready, tx_start, tx_din, grant, busy, word_done
  );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin scheduler that serialises words from two requesters, LSB byte first,
// into a byte-wide UART transmitter using its idle level as flow control.
module tx_scheduler #(
  parameter int N_DATA = 8,
  parameter int N_WORD = 32
) (
  input logic           clock,
  input logic           reset_i,
  tx_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT
  } state_t;

  state_t            state;
  logic [N_WORD-1:0] word_q;
  logic [1:0]        nbm1_q;
  logic [1:0]        idx_q;
  logic              prio_b;

  logic              pick_b;
  logic [N_WORD-1:0] win_data;
  logic [1:0]        win_nbm1;

  // B wins when it is alone, or when both ask and A was served last.
  always_comb begin
    pick_b   = bus.req_b_valid & (~bus.req_a_valid | prio_b);
    win_data = pick_b ? bus.req_b_data : bus.req_a_data;
    win_nbm1 = pick_b ? bus.req_b_nbytes_m1 : bus.req_a_nbytes_m1;
  end

  always_ff @(posedge clock or negedge reset_i) begin
    if (!reset_i) begin
      state           <= IDLE;
      word_q          <= '0;
      nbm1_q          <= '0;
      idx_q           <= '0;
      prio_b          <= 1'b0;
      bus.req_a_ready <= 1'b0;
      bus.req_b_ready <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.tx_din      <= '0;
      bus.grant       <= '0;
      bus.busy        <= 1'b0;
      bus.word_done   <= 1'b0;
    end else begin
      bus.req_a_ready <= 1'b0;
      bus.req_b_ready <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.word_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_a_valid || bus.req_b_valid) begin
            word_q          <= win_data;
            nbm1_q          <= win_nbm1;
            idx_q           <= '0;
            bus.tx_din      <= win_data[N_DATA-1:0];
            bus.grant       <= pick_b ? 2'b10 : 2'b01;
            bus.req_a_ready <= ~pick_b;
            bus.req_b_ready <= pick_b;
            prio_b          <= ~pick_b;
            bus.busy        <= 1'b1;
            state           <= LOAD;
          end
        end
        LOAD: state <= START;
        START: begin
          if (bus.tx_idle) begin
            bus.tx_start <= 1'b1;
            state        <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: if (!bus.tx_idle) state <= WAIT_IDLE;
        WAIT_IDLE: if (bus.tx_idle) state <= NEXT;
        NEXT: begin
          if (idx_q == nbm1_q) begin
            bus.word_done <= 1'b1;
            bus.grant     <= '0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            // The word is shifted down so the next byte always sits just above the current one.
            idx_q      <= idx_q + 2'd1;
            word_q     <= word_q >> N_DATA;
            bus.tx_din <= word_q[2*N_DATA-1:N_DATA];
            state      <= START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The block SHALL have parameter N_DATA, default 8, meaning UART byte width.
REQ-002 The block SHALL have parameter N_WORD, default 32, meaning requester word width (4 bytes).
REQ-003 The block SHALL have port clock  input  1  single system clock, rising edge.
REQ-004 The block SHALL have port reset_i  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_a_valid  input  1  requester A has a word to send.
REQ-006 The block SHALL have port req_a_data  input  N_WORD  requester A word.
REQ-007 The block SHALL have port req_a_nbytes_m1  input  2  requester A byte count minus one (0 to 1 byte, 3 to 4 bytes).
REQ-008 The block SHALL have port req_a_ready  output  1  one-cycle pulse meaning A word captured.
REQ-009 The block SHALL have ports req_b_valid, req_b_data, req_b_nbytes_m1 and req_b_ready, identical to A for requester B.
REQ-010 The block SHALL have port tx_start  output  1  start strobe to the UART transmitter.
REQ-011 The block SHALL have port tx_din  output  N_DATA  byte to the UART transmitter.
REQ-012 The block SHALL have port tx_idle  input  1  UART transmitter idle level (its tx_done_tick: high while idle, low while sending).
REQ-013 The block SHALL have port grant  output  2  one-hot owner of the current transfer (01 = A, 10 = B, 00 = none).
REQ-014 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 The block SHALL have port word_done  output  1  one-cycle pulse when the last byte of a word has completed.

Function
REQ-016 States SHALL be IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE, and NEXT; all outputs SHALL be registered.
REQ-017 IDLE: on a clock edge with any valid high, the block SHALL capture the winner's data and nbytes_m1, set grant, and go to LOAD.
REQ-018 Arbitration SHALL be round-robin: with both valid, the requester not served last wins; after reset, A wins first; with one valid, that requester wins.
REQ-019 LOAD: the winner's ready SHALL be high for exactly this cycle, byte index SHALL be 0, tx_din SHALL be data[7:0], then go to START.
REQ-020 START: if tx_idle is high, tx_start SHALL be high for exactly one cycle and the state SHALL go to WAIT_BUSY; otherwise the block SHALL stay in START with tx_start low.
REQ-021 WAIT_BUSY: the block SHALL wait until tx_idle is low, then go to WAIT_IDLE.
REQ-022 WAIT_IDLE: the block SHALL wait until tx_idle is high, then go to NEXT.
REQ-023 NEXT: if byte index equals nbytes_m1, word_done SHALL pulse, grant SHALL go to 00, and the state SHALL go to IDLE; otherwise the index SHALL increment, tx_din SHALL load data[8*index+7 : 8*index] (LSB byte first), and the state SHALL go to START.
REQ-024 tx_din SHALL be stable from START until the block leaves WAIT_IDLE for that byte.
REQ-025 Valid inputs SHALL be ignored outside IDLE; a requester SHALL hold valid, data and nbytes_m1 until its ready pulse.
REQ-026 A valid that drops before capture SHALL cause no transfer and no ready.
REQ-027 At most one ready SHALL be high in any cycle; ready and tx_start SHALL never be high in the same cycle.
REQ-028 Minimum spacing between captures SHALL be one full word transfer plus one IDLE cycle.

Reset
REQ-029 While reset_i is low, the block SHALL be in IDLE, tx_start = 0, tx_din = 0, grant = 00, busy = 0, word_done = 0, both ready = 0, and the round-robin pointer SHALL favour A.
REQ-030 Reset asserted mid-transfer SHALL take effect immediately (asynchronously) and discard the partial word; after release, the first capture SHALL need a fresh valid.

Verification
REQ-031 The bench SHALL cover this scenario: A valid, data = 0x11223344, nbytes_m1 = 3, UART model idle -> 4 tx_start pulses with tx_din = 0x44, 0x33, 0x22, 0x11 in order, req_a_ready pulses once, word_done pulses once.
REQ-032 The bench SHALL cover this scenario: A and B both valid after reset, nbytes_m1 = 0 each -> A is served first (grant = 01), then B (grant = 10); the next simultaneous request serves A again.
REQ-033 The bench SHALL cover this scenario: B valid, nbytes_m1 = 1, data = 0x0000BEEF -> exactly 2 bytes, 0xEF then 0xBE; byte 3 is never sent.
REQ-034 The bench SHALL cover this scenario: tx_idle held low for 20 cycles while in START -> tx_start stays low until tx_idle rises, then one pulse.
REQ-035 The bench SHALL cover this scenario: reset_i pulsed low after the second byte of a 4-byte word -> outputs reach reset values in the same cycle, no further tx_start, and no word_done.
REQ-036 The bench SHALL cover this scenario: B raises valid while A's word is in flight -> no req_b_ready until A's word_done; B is captured in the following IDLE cycle.
